// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the GRF write-port arbiter.
//   arb_state_e : starvation state machine encoding
//   REG_ZERO    : hard-wired zero register index
//   ptr_width() : FIFO pointer width (index bits plus one wrap bit)
package wb_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StStarve = 2'd2
  } arb_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for wb_port_arbiter.
//   w_*          : pipeline W-stage write request
//   s_*          : side-channel result handshake (s_valid/s_ready)
//   flush        : drop all queued side-channel results
//   grf_*        : GRF write port
//   stall_req    : bubble request to the hazard unit
//   pending_mask : registers targeted by live queued results
// slave = arbiter view, master = driver (pipeline/bench) view.
interface wb_port_arbiter_if;
  logic        w_we;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [31:0] w_pc;
  logic        s_valid;
  logic        s_ready;
  logic [4:0]  s_addr;
  logic [31:0] s_data;
  logic [31:0] s_pc;
  logic        flush;
  logic        grf_we;
  logic [4:0]  grf_addr;
  logic [31:0] grf_data;
  logic [31:0] grf_pc;
  logic        stall_req;
  logic [31:0] pending_mask;

  modport slave (
    input  w_we, w_addr, w_data, w_pc, s_valid, s_addr, s_data, s_pc, flush,
    output s_ready, grf_we, grf_addr, grf_data, grf_pc, stall_req, pending_mask
  );

  modport master (
    output w_we, w_addr, w_data, w_pc, s_valid, s_addr, s_data, s_pc, flush,
    input  s_ready, grf_we, grf_addr, grf_data, grf_pc, stall_req, pending_mask
  );
endinterface

// File: rtl/wb_side_fifo.sv
// Side-channel result FIFO with per-entry valid bits.
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   flush_i            : empty the FIFO and clear all valid bits
//   push_i, push_*_i   : store a new entry (valid=1)
//   pop_i              : retire the head entry (live or dead)
//   kill_i/kill_addr_i : invalidate every stored entry targeting kill_addr_i
//   empty_o, full_o    : occupancy flags from wrap-bit pointer compare
//   count_o            : stored entries, live or dead
//   head_*_o           : head entry fields and valid bit
//   pending_mask_o     : registered OR of one-hot addr over live entries
module wb_side_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter  int unsigned Depth = 4,
  localparam int unsigned PtrW  = ptr_width(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [4:0]      push_addr_i,
  input  logic [31:0]     push_data_i,
  input  logic [31:0]     push_pc_i,
  input  logic            pop_i,
  input  logic            kill_i,
  input  logic [4:0]      kill_addr_i,
  output logic            empty_o,
  output logic            full_o,
  output logic [PtrW-1:0] count_o,
  output logic            head_valid_o,
  output logic [4:0]      head_addr_o,
  output logic [31:0]     head_data_o,
  output logic [31:0]     head_pc_o,
  output logic [31:0]     pending_mask_o
);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW-2:0]  wr_idx, rd_idx;
  logic [Depth-1:0] valid_q, valid_d;
  logic [31:0]      mask_q, mask_d;
  logic [4:0]       addr_q [Depth];
  logic [4:0]       addr_d [Depth];
  logic [31:0]      data_q [Depth];
  logic [31:0]      data_d [Depth];
  logic [31:0]      pc_q   [Depth];
  logic [31:0]      pc_d   [Depth];

  assign wr_idx = wr_ptr_q[PtrW-2:0];
  assign rd_idx = rd_ptr_q[PtrW-2:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    pc_d     = pc_q;
    // Kill only pre-existing entries; the push below is younger and survives.
    if (kill_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (valid_q[i] && addr_q[i] == kill_addr_i) valid_d[i] = 1'b0;
      end
    end
    if (pop_i) begin
      valid_d[rd_idx] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PtrW'(1);
    end
    // Push after pop so a full-FIFO push into the freed slot keeps valid=1.
    if (push_i) begin
      addr_d[wr_idx]  = push_addr_i;
      data_d[wr_idx]  = push_data_i;
      pc_d[wr_idx]    = push_pc_i;
      valid_d[wr_idx] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (flush_i) begin
      valid_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    mask_d = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (valid_d[i]) mask_d[addr_d[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
      mask_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      mask_q   <= mask_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    addr_q <= addr_d;
    data_q <= data_d;
    pc_q   <= pc_d;
  end

  assign empty_o        = (wr_ptr_q == rd_ptr_q);
  assign full_o         = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {(PtrW-1){1'b0}}});
  assign count_o        = wr_ptr_q - rd_ptr_q;
  assign head_valid_o   = valid_q[rd_idx];
  assign head_addr_o    = addr_q[rd_idx];
  assign head_data_o    = data_q[rd_idx];
  assign head_pc_o      = pc_q[rd_idx];
  assign pending_mask_o = mask_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// GRF write-port arbiter: pipeline writeback has absolute priority and passes
// through combinationally; side-channel results queue in wb_side_fifo and
// drain in idle write slots. A starvation counter raises stall_req so the
// queue cannot wait forever.
//   clk   : system clock, rising edge
//   reset : synchronous active-low reset
//   bus   : wb_port_arbiter_if.slave (pipeline, side channel, GRF port,
//           stall_req, pending_mask)
// Parameters: DEPTH (FIFO entries, power of two 2..16),
//             STARVE_LIMIT (busy slots tolerated before stall_req, 1..255).
// Build option: define WB_TRACE_EN for a simulation-only GRF write trace.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               reset,
  wb_port_arbiter_if.slave  bus
);

  localparam int unsigned PtrW = ptr_width(DEPTH);

  logic            busy, pop, push, accept, ready_int, empty_next;
  logic            fifo_empty, fifo_full, head_valid;
  logic [PtrW-1:0] count, count_next;
  logic [4:0]      head_addr;
  logic [31:0]     head_data, head_pc, fifo_mask;
  arb_state_e      state_q, state_d;
  logic [7:0]      starve_q, starve_d;

  logic        grf_we, s_ready, stall_req;
  logic [4:0]  grf_addr;
  logic [31:0] grf_data, grf_pc, pending_mask;

  // Writes to $0 leave the slot free for the side channel.
  assign busy       = bus.w_we && (bus.w_addr != REG_ZERO);
  assign pop        = !busy && !fifo_empty && !bus.flush;
  assign ready_int  = !fifo_full || pop;
  assign accept     = bus.s_valid && ready_int && !bus.flush;
  // $0 results are handshaken but never stored.
  assign push       = accept && (bus.s_addr != REG_ZERO);
  assign count_next = count + PtrW'(push) - PtrW'(pop);
  assign empty_next = (count_next == '0);

  wb_side_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i          (clk),
    .rst_ni         (reset),
    .flush_i        (bus.flush),
    .push_i         (push),
    .push_addr_i    (bus.s_addr),
    .push_data_i    (bus.s_data),
    .push_pc_i      (bus.s_pc),
    .pop_i          (pop),
    .kill_i         (busy),
    .kill_addr_i    (bus.w_addr),
    .empty_o        (fifo_empty),
    .full_o         (fifo_full),
    .count_o        (count),
    .head_valid_o   (head_valid),
    .head_addr_o    (head_addr),
    .head_data_o    (head_data),
    .head_pc_o      (head_pc),
    .pending_mask_o (fifo_mask)
  );

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (bus.flush) begin
      state_d  = StIdle;
      starve_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          starve_d = '0;
          if (push) state_d = StWait;
        end
        StWait: begin
          if (pop) begin
            starve_d = '0;
            state_d  = empty_next ? StIdle : StWait;
          end else if (busy) begin
            starve_d = starve_q + 8'd1;
            if (starve_d == 8'(STARVE_LIMIT)) state_d = StStarve;
          end
        end
        StStarve: begin
          if (pop) begin
            starve_d = '0;
            state_d  = empty_next ? StIdle : StWait;
          end
        end
        default: begin
          state_d  = StIdle;
          starve_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Outputs are forced to their idle values while reset is held.
  always_comb begin
    grf_we       = 1'b0;
    grf_addr     = '0;
    grf_data     = '0;
    grf_pc       = '0;
    s_ready      = 1'b1;
    stall_req    = 1'b0;
    pending_mask = '0;
    if (reset) begin
      s_ready      = ready_int;
      stall_req    = (state_q == StStarve);
      pending_mask = fifo_mask;
      if (busy) begin
        grf_we   = 1'b1;
        grf_addr = bus.w_addr;
        grf_data = bus.w_data;
        grf_pc   = bus.w_pc;
      end else if (pop && head_valid) begin
        grf_we   = 1'b1;
        grf_addr = head_addr;
        grf_data = head_data;
        grf_pc   = head_pc;
      end
    end
  end

  assign bus.grf_we       = grf_we;
  assign bus.grf_addr     = grf_addr;
  assign bus.grf_data     = grf_data;
  assign bus.grf_pc       = grf_pc;
  assign bus.s_ready      = s_ready;
  assign bus.stall_req    = stall_req;
  assign bus.pending_mask = pending_mask;

`ifdef WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (grf_we && grf_addr != REG_ZERO) begin
      $display("@%h: $%d <= %h", grf_pc, grf_addr, grf_data);
    end
  end
`else
  // Trace disabled.
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    bit          live;
  } ent_t;

  typedef struct {
    bit          we;
    bit          ready;
    bit          stall;
    logic [31:0] mask;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } stat_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } wr_t;

  // Reference model: queue of outstanding results plus a starvation tally.
  ent_t  mq[$];
  int    starve = 0;
  bit    starving = 1'b0;

  stat_t stat_q[$];
  wr_t   wr_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // One clock of stimulus: drive, predict, push expectations, advance model.
  task automatic cycle(input bit rn, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [31:0] wp,
                       input bit sv, input logic [4:0] sa,
                       input logic [31:0] sd, input logic [31:0] sp, input bit fl);
    stat_t       st;
    wr_t         w;
    ent_t        e;
    bit          busy, pop, ready, had;
    logic [31:0] mask;
    rst_n = rn;
    bus.w_we = we;  bus.w_addr = wa; bus.w_data = wd; bus.w_pc = wp;
    bus.s_valid = sv; bus.s_addr = sa; bus.s_data = sd; bus.s_pc = sp;
    bus.flush = fl;

    busy  = we && (wa != 5'd0);
    pop   = !busy && (mq.size() > 0) && !fl;
    ready = (mq.size() < DEPTH) || pop;
    st = '{default: '0};
    st.ready = 1'b1;
    if (rn) begin
      st.ready = ready;
      st.stall = starving;
      mask = '0;
      foreach (mq[i]) if (mq[i].live) mask[mq[i].addr] = 1'b1;
      st.mask = mask;
      if (busy) begin
        st.we = 1'b1; st.addr = wa; st.data = wd; st.pc = wp;
      end else if (pop && mq[0].live) begin
        st.we = 1'b1; st.addr = mq[0].addr; st.data = mq[0].data; st.pc = mq[0].pc;
      end
    end
    stat_q.push_back(st);
    if (st.we) begin
      w.addr = st.addr; w.data = st.data; w.pc = st.pc;
      wr_q.push_back(w);
    end

    @(posedge clk);
    had = (mq.size() > 0);
    if (!rn || fl) begin
      mq.delete();
      starve = 0;
      starving = 1'b0;
    end else begin
      if (busy) foreach (mq[i]) if (mq[i].addr == wa) mq[i].live = 1'b0;
      if (pop) void'(mq.pop_front());
      if (sv && ready && sa != 5'd0) begin
        e.addr = sa; e.data = sd; e.pc = sp; e.live = 1'b1;
        mq.push_back(e);
      end
      if (pop) begin
        starve = 0;
        starving = 1'b0;
      end else if (had && !starving && busy) begin
        starve++;
        if (starve == LIMIT) starving = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle();
    cycle(1, 0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
  endtask

  // Monitor: one status record per cycle; GRF writes drain the write scoreboard.
  stat_t mst;
  wr_t   mw;
  always @(negedge clk) begin
    if (stat_q.size() > 0) begin
      mst = stat_q.pop_front();
      chk("grf_we", 32'(bus.grf_we), 32'(mst.we));
      chk("s_ready", 32'(bus.s_ready), 32'(mst.ready));
      chk("stall_req", 32'(bus.stall_req), 32'(mst.stall));
      chk("pending_mask", bus.pending_mask, mst.mask);
      if (bus.grf_we) begin
        if (wr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL grf_write: got write $%0d=%h with none expected at %0t",
                   bus.grf_addr, bus.grf_data, $time);
        end else begin
          mw = wr_q.pop_front();
          chk("grf_addr", 32'(bus.grf_addr), 32'(mw.addr));
          chk("grf_data", bus.grf_data, mw.data);
          chk("grf_pc", bus.grf_pc, mw.pc);
        end
      end else begin
        chk("grf_addr_idle", 32'(bus.grf_addr), 32'(mst.addr));
        chk("grf_data_idle", bus.grf_data, mst.data);
        chk("grf_pc_idle", bus.grf_pc, mst.pc);
      end
    end
  end

  int busy_pct;

  initial begin
    bus.w_we = 0; bus.w_addr = 0; bus.w_data = 0; bus.w_pc = 0;
    bus.s_valid = 0; bus.s_addr = 0; bus.s_data = 0; bus.s_pc = 0; bus.flush = 0;
    @(posedge clk);
    #1;

    // Reset with every input active, then release.
    repeat (3) cycle(0, 1, 5'd7, 32'hDEAD, 32'h100, 1, 5'd3, 32'hBEEF, 32'h200, 1);
    idle();

    // Pipeline pass-through, then a single side-channel result.
    cycle(1, 1, 5'd5, 32'h1234, 32'h3000, 0, 5'd0, 0, 0, 0);
    cycle(1, 0, 5'd0, 0, 0, 1, 5'd8, 32'hAA, 32'h3004, 0);
    idle();
    idle();

    // Fill under a busy pipeline, hold a fifth result, provoke starvation.
    for (int i = 1; i <= 4; i++)
      cycle(1, 1, 5'd20, 32'(i * 16), 32'h4000, 1, 5'(i), 32'(i), 32'(32'h5000 + i), 0);
    repeat (LIMIT) cycle(1, 1, 5'd21, 32'h77, 32'h4100, 1, 5'd5, 32'h55, 32'h5005, 0);
    cycle(1, 0, 5'd0, 0, 0, 1, 5'd5, 32'h55, 32'h5005, 0);
    repeat (6) idle();

    // WAW kill, and a same-edge enqueue that must survive.
    cycle(1, 0, 5'd0, 0, 0, 1, 5'd9, 32'h99, 32'h6000, 0);
    cycle(1, 1, 5'd9, 32'h909, 32'h6004, 0, 5'd0, 0, 0, 0);
    idle();
    cycle(1, 1, 5'd9, 32'h919, 32'h6008, 1, 5'd9, 32'h929, 32'h600C, 0);
    idle();
    idle();

    // $0 handling on both sides.
    cycle(1, 0, 5'd0, 0, 0, 1, 5'd0, 32'h123, 32'h7000, 0);
    idle();
    cycle(1, 1, 5'd3, 32'h33, 32'h7004, 1, 5'd12, 32'hC0C0, 32'h7008, 0);
    cycle(1, 1, 5'd0, 32'hFFFF, 32'h700C, 0, 5'd0, 0, 0, 0);
    idle();

    // Flush with three queued results and a concurrent s_valid.
    cycle(1, 1, 5'd1, 32'h1, 32'h8000, 1, 5'd13, 32'hD, 32'h8004, 0);
    cycle(1, 1, 5'd2, 32'h2, 32'h8008, 1, 5'd14, 32'hE, 32'h800C, 0);
    cycle(1, 1, 5'd4, 32'h4, 32'h8010, 1, 5'd15, 32'hF, 32'h8014, 0);
    cycle(1, 1, 5'd6, 32'h6, 32'h8018, 1, 5'd7, 32'h7, 32'h801C, 1);
    repeat (3) idle();

    // Randomized traffic with phases of varying pipeline pressure.
    busy_pct = 30;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: busy_pct = 30;
          1: busy_pct = 70;
          default: busy_pct = 95;
        endcase
      end
      cycle(($urandom_range(0, 255) != 0),
            ($urandom_range(0, 99) < busy_pct),
            5'($urandom_range(0, 7)), $urandom, $urandom,
            ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 7)), $urandom, $urandom,
            ($urandom_range(0, 63) == 0));
    end
    repeat (DEPTH + 2) idle();

    @(negedge clk);
    #1;
    chk("leftover_writes", 32'(wr_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
